// File: rtl/reg_dump_unit_if.sv
// Register-dump bus: sweep control, register-file read port and the word stream.
// The master modport is the dump engine; the slave modport is its environment.
interface reg_dump_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Start;
  logic                  Abort;
  logic [ADDR_WIDTH-1:0] First_Reg;
  logic [ADDR_WIDTH-1:0] Last_Reg;
  logic [ADDR_WIDTH-1:0] Rd_Reg;
  logic [DATA_WIDTH-1:0] Rd_Data;
  logic [ADDR_WIDTH-1:0] Out_Addr;
  logic [DATA_WIDTH-1:0] Out_Data;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic                  Busy;
  logic                  Done;

  modport master (
    input  Start, Abort, First_Reg, Last_Reg, Rd_Data, Out_Ready,
    output Rd_Reg, Out_Addr, Out_Data, Out_Valid, Busy, Done
  );

  modport slave (
    output Start, Abort, First_Reg, Last_Reg, Rd_Data, Out_Ready,
    input  Rd_Reg, Out_Addr, Out_Data, Out_Valid, Busy, Done
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Streams a wrapping range of register-file words as (addr, data) beats; 2 cycles per word.
// Each beat holds in HOLD until Out_Ready; every stalled cycle adds one cycle, nothing dropped.
module reg_dump_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           CLK,
  input  logic           RST,
  reg_dump_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] end_reg;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  // Outputs are registers or pure state decodes, so Out_Ready never reaches them combinationally.
  assign bus.Rd_Reg    = cnt;
  assign bus.Out_Addr  = out_addr;
  assign bus.Out_Data  = out_data;
  assign bus.Out_Valid = (state == HOLD);
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      end_reg  <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else if (bus.Abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            cnt     <= bus.First_Reg;
            end_reg <= bus.Last_Reg;
            state   <= READ;
          end
        end
        READ: begin
          out_addr <= cnt;
          out_data <= bus.Rd_Data;
          state    <= HOLD;
        end
        HOLD: begin
          if (bus.Out_Ready) begin
            if (cnt == end_reg) begin
              state <= DONE;
            end else begin
              // Natural overflow of the counter gives the wrap past the top register.
              cnt   <= cnt + 1'b1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit with a behavioural register file on the read port.
module tb_reg_dump_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  reg_dump_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_dump_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [31:0] regs [32];
  assign bus.Rd_Data = regs[bus.Rd_Reg];

  int checks = 0;
  int errors = 0;

  logic [4:0]  got_addr [64];
  logic [31:0] got_data [64];
  int          got_edge [64];
  int          got_n, done_c, idle_c, done_pulses;
  logic        busy0;

  // Stimulus only: must be called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_sweep(input logic [4:0] first, input logic [4:0] last);
    bus.Start     = 1'b1;
    bus.First_Reg = first;
    bus.Last_Reg  = last;
    @(negedge CLK);
    bus.Start     = 1'b0;
  endtask

  // Records beats with Ready high; c counts edges after the accepting edge.
  task automatic collect(input int max_c);
    got_n = 0; done_c = -1; idle_c = -1; done_pulses = 0; busy0 = 1'b0;
    bus.Out_Ready = 1'b1;
    for (int c = 0; c < max_c; c++) begin
      if (c == 0) busy0 = bus.Busy;
      if (bus.Out_Valid && bus.Out_Ready && got_n < 64) begin
        got_addr[got_n] = bus.Out_Addr;
        got_data[got_n] = bus.Out_Data;
        got_edge[got_n] = c + 1;
        got_n++;
      end
      if (bus.Done) begin
        done_pulses++;
        if (done_c < 0) done_c = c;
      end
      if (!bus.Busy && c > 0) begin
        idle_c = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (bus.Rd_Reg !== 5'd0) begin errors++; $display("FAIL reset_rd_reg got %0d want 0", bus.Rd_Reg); end
    checks++; if (bus.Out_Addr !== 5'd0) begin errors++; $display("FAIL reset_out_addr got %0d want 0", bus.Out_Addr); end
    checks++; if (bus.Out_Data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.Out_Data); end
    checks++; if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.Out_Valid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.Done); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_full_sweep();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
    start_sweep(5'd0, 5'd31);
    collect(200);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy_after_start got %b want 1", busy0); end
    checks++; if (got_n != 32) begin errors++; $display("FAIL full_count got %0d want 32", got_n); end
    for (int i = 0; i < got_n && i < 32; i++) begin
      checks++;
      if (got_addr[i] !== 5'(i) || got_data[i] !== 32'(i) * 32'h11111111 || got_edge[i] != 2 + 2 * i) begin
        errors++;
        $display("FAIL full_word%0d got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                 i, got_addr[i], got_data[i], got_edge[i], i, 32'(i) * 32'h11111111, 2 + 2 * i);
      end
    end
    checks++; if (done_c != 64) begin errors++; $display("FAIL full_done_time got %0d want 64", done_c); end
    checks++; if (idle_c != 65) begin errors++; $display("FAIL full_idle_time got %0d want 65", idle_c); end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_pulses); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_a [4];
    exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
    start_sweep(5'd30, 5'd1);
    collect(50);
    checks++; if (got_n != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got_n); end
    for (int i = 0; i < got_n && i < 4; i++) begin
      checks++;
      if (got_addr[i] !== exp_a[i] || got_data[i] !== regs[exp_a[i]]) begin
        errors++;
        $display("FAIL wrap_word%0d got addr %0d data %h want addr %0d data %h",
                 i, got_addr[i], got_data[i], exp_a[i], regs[exp_a[i]]);
      end
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL wrap_done_pulses got %0d want 1", done_pulses); end
  endtask

  task automatic test_single();
    regs[7] = 32'hDEADBEEF;
    start_sweep(5'd7, 5'd7);
    collect(20);
    checks++; if (got_n != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_n); end
    checks++;
    if (got_addr[0] !== 5'd7 || got_data[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_word got addr %0d data %h want addr 7 data deadbeef", got_addr[0], got_data[0]);
    end
    checks++; if (done_c != 2) begin errors++; $display("FAIL single_done_time got %0d want 2", done_c); end
    checks++; if (idle_c != 3) begin errors++; $display("FAIL single_idle_time got %0d want 3", idle_c); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  pat;
    logic [4:0]  prev_a;
    logic [31:0] prev_d;
    logic        prev_v, prev_hs, hs;
    int          n, pulses, idle;
    pat = 5'b10100;
    prev_v = 1'b0; prev_hs = 1'b0; prev_a = '0; prev_d = '0;
    n = 0; pulses = 0; idle = 0;
    bus.Out_Ready = 1'b0;
    start_sweep(5'd2, 5'd4);
    for (int c = 0; c < 40; c++) begin
      if (prev_v && !prev_hs) begin
        checks++;
        if (bus.Out_Valid !== 1'b1 || bus.Out_Addr !== prev_a || bus.Out_Data !== prev_d) begin
          errors++;
          $display("FAIL bp_stable c%0d got v %b addr %0d data %h want v 1 addr %0d data %h",
                   c, bus.Out_Valid, bus.Out_Addr, bus.Out_Data, prev_a, prev_d);
        end
      end
      if (bus.Done) pulses++;
      if (!bus.Busy && c > 0) begin
        idle = 1;
        break;
      end
      bus.Out_Ready = (c < 5) ? pat[c] : 1'b1;
      bus.Start     = (c < 6) && (c % 2 == 1);
      bus.First_Reg = 5'd20;
      bus.Last_Reg  = 5'd25;
      hs = bus.Out_Valid && bus.Out_Ready;
      if (hs) begin
        checks++;
        if (bus.Out_Addr !== 5'(2 + n) || bus.Out_Data !== regs[2 + n]) begin
          errors++;
          $display("FAIL bp_word%0d got addr %0d data %h want addr %0d data %h",
                   n, bus.Out_Addr, bus.Out_Data, 2 + n, regs[2 + n]);
        end
        n++;
      end
      prev_v = bus.Out_Valid; prev_hs = hs; prev_a = bus.Out_Addr; prev_d = bus.Out_Data;
      @(negedge CLK);
    end
    bus.Start = 1'b0;
    bus.Out_Ready = 1'b1;
    checks++; if (n != 3) begin errors++; $display("FAIL bp_count got %0d want 3", n); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bp_done_pulses got %0d want 1", pulses); end
    checks++; if (idle != 1) begin errors++; $display("FAIL bp_finish got %0d want 1", idle); end
  endtask

  task automatic test_abort();
    int pulses;
    bus.Out_Ready = 1'b0;
    start_sweep(5'd5, 5'd9);
    @(negedge CLK);
    checks++;
    if (bus.Out_Valid !== 1'b1 || bus.Out_Addr !== 5'd5) begin
      errors++;
      $display("FAIL abort_hold got v %b addr %0d want v 1 addr 5", bus.Out_Valid, bus.Out_Addr);
    end
    bus.Abort = 1'b1;
    @(negedge CLK);
    bus.Abort = 1'b0;
    checks++; if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.Out_Valid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
    checks++;
    if (bus.Out_Addr !== 5'd5 || bus.Out_Data !== regs[5]) begin
      errors++;
      $display("FAIL abort_keep got addr %0d data %h want addr 5 data %h", bus.Out_Addr, bus.Out_Data, regs[5]);
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.Done) pulses++;
      @(negedge CLK);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", pulses); end
    bus.Start = 1'b1; bus.Abort = 1'b1; bus.First_Reg = 5'd0; bus.Last_Reg = 5'd0;
    @(negedge CLK);
    bus.Start = 1'b0; bus.Abort = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_wins_busy got %b want 0", bus.Busy); end
    start_sweep(5'd0, 5'd0);
    collect(20);
    checks++;
    if (got_n != 1 || got_addr[0] !== 5'd0 || got_data[0] !== regs[0]) begin
      errors++;
      $display("FAIL abort_resweep got n %0d addr %0d data %h want n 1 addr 0 data %h",
               got_n, got_addr[0], got_data[0], regs[0]);
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL abort_resweep_done got %0d want 1", done_pulses); end
  endtask

  task automatic test_async_reset();
    bus.Out_Ready = 1'b1;
    start_sweep(5'd12, 5'd15);
    checks++; if (bus.Rd_Reg !== 5'd12) begin errors++; $display("FAIL arst_pre_rd_reg got %0d want 12", bus.Rd_Reg); end
    #2 RST = 1'b1;
    #1;
    checks++; if (bus.Rd_Reg !== 5'd0) begin errors++; $display("FAIL arst_rd_reg got %0d want 0", bus.Rd_Reg); end
    checks++; if (bus.Out_Addr !== 5'd0) begin errors++; $display("FAIL arst_out_addr got %0d want 0", bus.Out_Addr); end
    checks++; if (bus.Out_Data !== 32'd0) begin errors++; $display("FAIL arst_out_data got %h want 0", bus.Out_Data); end
    checks++;
    if (bus.Out_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL arst_flags got v %b busy %b done %b want 0 0 0", bus.Out_Valid, bus.Busy, bus.Done);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start_sweep(5'd3, 5'd4);
    collect(30);
    checks++;
    if (got_n != 2 || got_addr[0] !== 5'd3 || got_addr[1] !== 5'd4 ||
        got_data[0] !== regs[3] || got_data[1] !== regs[4]) begin
      errors++;
      $display("FAIL arst_resweep got n %0d addr %0d,%0d want n 2 addr 3,4", got_n, got_addr[0], got_addr[1]);
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL arst_resweep_done got %0d want 1", done_pulses); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.First_Reg = '0; bus.Last_Reg = '0; bus.Out_Ready = 1'b1;
    test_reset();
    test_full_sweep();
    test_wrap();
    test_single();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
